// File: rtl/audio_dac_serializer.sv
// Serializes the ROM word selected by Add to the codec DAC port in left-justified
// format, generating BCLK/LRCK locally and handshaking with the address generator.
module audio_dac_serializer #(
   parameter int BCLK_DIV = 16,
   parameter int ROM_LAT  = 2
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        INIT_FINISH,
   input  logic [16:0] Add,
   input  logic [15:0] sample_in,
   output logic        AUD_BCLK,
   output logic        AUD_DACLRCK,
   output logic        AUD_DACDAT,
   output logic        data_over,
   output logic        underrun
);

   localparam int DIV_W = $clog2(BCLK_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
   localparam logic [2:0]       LAT     = 3'(ROM_LAT);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             bclk_q, bclk_d;
   logic [4:0]       bit_q, bit_d;
   logic             first_q, first_d;
   logic [16:0]      add_q;
   logic [2:0]       dly_q, dly_d;
   logic [15:0]      pending_q, pending_d;
   logic [15:0]      word_q, word_d;
   logic             fresh_q, fresh_d;
   logic             lrck_q, lrck_d;
   logic             dat_q, dat_d;
   logic             over_q, over_d;
   logic             under_q, under_d;
   logic             fall;
   logic             latch;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         div_q     <= '0;
         bclk_q    <= 1'b0;
         bit_q     <= '0;
         first_q   <= 1'b1;
         add_q     <= '0;
         dly_q     <= '0;
         pending_q <= '0;
         word_q    <= '0;
         fresh_q   <= 1'b0;
         lrck_q    <= 1'b0;
         dat_q     <= 1'b0;
         over_q    <= 1'b0;
         under_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bclk_q    <= bclk_d;
         bit_q     <= bit_d;
         first_q   <= first_d;
         add_q     <= Add;
         dly_q     <= dly_d;
         pending_q <= pending_d;
         word_q    <= word_d;
         fresh_q   <= fresh_d;
         lrck_q    <= lrck_d;
         dat_q     <= dat_d;
         over_q    <= over_d;
         under_q   <= under_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bclk_d    = bclk_q;
      bit_d     = bit_q;
      first_d   = first_q;
      dly_d     = dly_q;
      pending_d = pending_q;
      word_d    = word_q;
      fresh_d   = fresh_q;
      lrck_d    = lrck_q;
      dat_d     = dat_q;
      over_d    = over_q;
      under_d   = 1'b0;
      fall      = 1'b0;
      latch     = 1'b0;

      case (state_q)
         IDLE: begin
            if (INIT_FINISH) state_d = RUN;
         end
         RUN: begin
            if (!INIT_FINISH) begin
               state_d   = IDLE;
               div_d     = '0;
               bclk_d    = 1'b0;
               bit_d     = '0;
               first_d   = 1'b1;
               dly_d     = '0;
               pending_d = '0;
               word_d    = '0;
               fresh_d   = 1'b0;
               lrck_d    = 1'b0;
               dat_d     = 1'b0;
               over_d    = 1'b0;
            end else begin
               if (div_q == DIV_MAX) begin
                  div_d  = '0;
                  bclk_d = ~bclk_q;
                  fall   = bclk_q;
               end else begin
                  div_d = div_q + DIV_ONE;
               end

               // The first falling toggle after entry opens slot 0 instead of advancing.
               if (fall) begin
                  if (first_q) begin
                     bit_d   = '0;
                     first_d = 1'b0;
                     latch   = 1'b1;
                  end else begin
                     bit_d = bit_q + 5'd1;
                     latch = (bit_q == 5'd31);
                  end
                  if (latch) begin
                     word_d  = pending_q;
                     fresh_d = 1'b0;
                     over_d  = 1'b1;
                     under_d = ~fresh_q;
                  end
                  lrck_d = bit_d[4];
                  dat_d  = word_d[~bit_d[3:0]];
               end

               // Capture is evaluated after the latch so it wins for fresh/data_over.
               if (Add != add_q) begin
                  dly_d = LAT;
               end else if (dly_q != 3'd0) begin
                  dly_d = dly_q - 3'd1;
                  if (dly_q == 3'd1) begin
                     pending_d = sample_in;
                     fresh_d   = 1'b1;
                     over_d    = 1'b0;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign AUD_BCLK    = bclk_q;
   assign AUD_DACLRCK = lrck_q;
   assign AUD_DACDAT  = dat_q;
   assign data_over   = over_q;
   assign underrun    = under_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer at default parameters; cycle numbers are
// counted from the Clk edge that enters RUN.
module tb_audio_dac_serializer;

   logic        Clk;
   logic        Reset_n;
   logic        INIT_FINISH;
   logic [16:0] Add;
   logic [15:0] sample_in;
   logic        AUD_BCLK;
   logic        AUD_DACLRCK;
   logic        AUD_DACDAT;
   logic        data_over;
   logic        underrun;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   audio_dac_serializer #(.BCLK_DIV(16), .ROM_LAT(2)) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .INIT_FINISH (INIT_FINISH),
      .Add         (Add),
      .sample_in   (sample_in),
      .AUD_BCLK    (AUD_BCLK),
      .AUD_DACLRCK (AUD_DACLRCK),
      .AUD_DACDAT  (AUD_DACDAT),
      .data_over   (data_over),
      .underrun    (underrun)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end else begin
         $display("ok   %s cyc=%0d val=%h", tag, cyc, got);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
      cyc++;
   endtask

   task automatic tick_to(input int target);
      while (cyc < target) tick();
   endtask

   // Samples DACDAT and LRCK at the 32 BCLK rising edges of the frame latched at 'start'.
   task automatic collect_frame(input int start, output logic [31:0] dat, output logic [31:0] lr);
      dat = '0;
      lr  = '0;
      for (int k = 0; k < 32; k++) begin
         tick_to(start + 16 + 32 * k);
         dat = {dat[30:0], AUD_DACDAT};
         lr  = {lr[30:0], AUD_DACLRCK};
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_bclk"}, 32'(AUD_BCLK), 32'd0);
      check_eq({tag, "_lrck"}, 32'(AUD_DACLRCK), 32'd0);
      check_eq({tag, "_dat"}, 32'(AUD_DACDAT), 32'd0);
      check_eq({tag, "_over"}, 32'(data_over), 32'd0);
      check_eq({tag, "_under"}, 32'(underrun), 32'd0);
   endtask

   logic [31:0] dat_v;
   logic [31:0] lr_v;
   int          n;

   initial begin
      Reset_n     = 1'b0;
      INIT_FINISH = 1'b1;
      Add         = 17'd0;
      sample_in   = 16'h0000;

      repeat (5) @(posedge Clk);
      @(negedge Clk);
      check_outputs_zero("reset");
      Reset_n = 1'b1;

      // Entry edge, then count edges up to the first BCLK rise.
      tick();
      cyc = 0;
      n = 0;
      while (!AUD_BCLK && n < 100) begin
         tick();
         n++;
      end
      check_eq("first_rise", 32'(n), 32'd16);

      tick_to(31);
      check_eq("over_pre_latch", 32'(data_over), 32'd0);
      tick_to(32);
      check_eq("over_latch0", 32'(data_over), 32'd1);
      check_eq("under_latch0", 32'(underrun), 32'd1);
      tick_to(33);
      check_eq("under_pulse_end", 32'(underrun), 32'd0);

      // Handshake: capture lands 3 Clks after the Add change.
      tick_to(100);
      Add       = 17'd1;
      sample_in = 16'hA5C3;
      tick_to(102);
      check_eq("over_before_cap", 32'(data_over), 32'd1);
      tick_to(103);
      check_eq("over_after_cap", 32'(data_over), 32'd0);

      tick_to(1056);
      check_eq("under_frame1", 32'(underrun), 32'd0);
      check_eq("over_frame1", 32'(data_over), 32'd1);
      collect_frame(1056, dat_v, lr_v);
      check_eq("frame1_dat", dat_v, 32'hA5C3A5C3);
      check_eq("frame1_lrck", lr_v, 32'h0000FFFF);

      // No new sample: the word repeats with an underrun pulse.
      tick_to(2080);
      check_eq("under_frame2", 32'(underrun), 32'd1);
      tick_to(2081);
      check_eq("under_frame2_end", 32'(underrun), 32'd0);

      // Coalescing 5 -> 6 -> 7 on consecutive Clks.
      tick_to(2200);
      Add = 17'd5; sample_in = 16'd5;
      tick();
      Add = 17'd6; sample_in = 16'd6;
      tick();
      Add = 17'd7; sample_in = 16'd7;
      tick_to(2204);
      check_eq("coal_over_hold", 32'(data_over), 32'd1);
      tick_to(2205);
      check_eq("coal_over_cap", 32'(data_over), 32'd0);

      tick_to(3104);
      check_eq("under_frame3", 32'(underrun), 32'd0);
      collect_frame(3104, dat_v, lr_v);
      check_eq("frame3_dat", dat_v, 32'h00070007);

      // Collision: capture on the frame-latch Clk of frame 4.
      tick_to(4125);
      Add = 17'd2; sample_in = 16'h3C5A;
      tick_to(4128);
      check_eq("coll_over", 32'(data_over), 32'd0);
      check_eq("coll_under", 32'(underrun), 32'd1);
      collect_frame(4128, dat_v, lr_v);
      check_eq("frame4_dat", dat_v, 32'h00070007);
      tick_to(5152);
      check_eq("under_frame5", 32'(underrun), 32'd0);
      check_eq("over_frame5", 32'(data_over), 32'd1);
      collect_frame(5152, dat_v, lr_v);
      check_eq("frame5_dat", dat_v, 32'h3C5A3C5A);

      // Init drop in slot 20 of frame 6 while BCLK is high.
      tick_to(6835);
      check_eq("pre_drop_bclk", 32'(AUD_BCLK), 32'd1);
      check_eq("pre_drop_lrck", 32'(AUD_DACLRCK), 32'd1);
      check_eq("pre_drop_dat", 32'(AUD_DACDAT), 32'd1);
      INIT_FINISH = 1'b0;
      tick();
      check_outputs_zero("drop");

      tick();
      tick();
      INIT_FINISH = 1'b1;
      tick();
      cyc = 0;
      tick_to(5);
      Add = 17'd1; sample_in = 16'hA5C3;
      tick_to(15);
      check_eq("re_bclk_low", 32'(AUD_BCLK), 32'd0);
      tick_to(16);
      check_eq("re_bclk_rise", 32'(AUD_BCLK), 32'd1);
      tick_to(31);
      check_eq("re_over_pre", 32'(data_over), 32'd0);
      tick_to(32);
      check_eq("re_under", 32'(underrun), 32'd0);
      check_eq("re_over", 32'(data_over), 32'd1);
      check_eq("re_lrck", 32'(AUD_DACLRCK), 32'd0);
      collect_frame(32, dat_v, lr_v);
      check_eq("re_frame_dat", dat_v, 32'hA5C3A5C3);
      check_eq("re_frame_lrck", lr_v, 32'h0000FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
